// File: rtl/load_unit.sv
// Multi-cycle load datapath: base + sign-extended offset, memory read, RF writeback.
// Optional alignment check enabled by defining LOAD_ALIGN_CHECK_EN.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      launch a load (sampled only when idle)
//   instruction                offset source, low IMM_W bits
//   base_addr, dest_reg        base register value and destination register
//   mem_rd_en, mem_addr        read request and registered effective address
//   mem_rd_data, mem_rd_valid  returned read word and its valid strobe
//   rf_we, rf_waddr, rf_wdata  one-cycle register-file write port
//   busy, done, error          status: busy unless idle, done/error pulses
module load_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int IMM_W    = 16,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IMM_W-1:0]  instruction,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [REG_AW-1:0] dest_reg,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, REQ, WB, ERR
  } state_t;

  state_t              state_q, state_d;
  logic [IMM_W-1:0]    imm_q;
  logic [ADDR_W-1:0]   base_q;
  logic [REG_AW-1:0]   waddr_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       cnt_inc;
  logic [ADDR_W-1:0]   ea;
  logic                cap;

  // Carry out of the add is dropped: addresses wrap modulo 2^ADDR_W.
  assign ea = base_q
            + {{(ADDR_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign cnt_inc = cnt_q + CW'(1);
  assign cap = (state_q == IDLE) && start;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    mem_rd_en = 1'b0;
    rf_we     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = ADDR;
      end
      ADDR: begin
        addr_d  = ea;
        cnt_d   = '0;
`ifdef LOAD_ALIGN_CHECK_EN
        if (ea[1:0] != 2'b00) state_d = ERR;
        else                  state_d = REQ;
`else
        state_d = REQ;
`endif
      end
      REQ: begin
        mem_rd_en = 1'b1;
        cnt_d     = cnt_inc;
        // cnt_inc counts this cycle, so exit after MAX_WAIT REQ cycles.
        if (mem_rd_valid) begin
          wdata_d = mem_rd_data;
          state_d = WB;
        end else if (cnt_inc == CW'(MAX_WAIT)) begin
          state_d = ERR;
        end
      end
      WB: begin
        rf_we   = (waddr_q != '0);
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        error   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      imm_q   <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        imm_q   <= instruction;
        base_q  <= base_addr;
        waddr_q <= dest_reg;
      end
    end
  end

  assign mem_addr = addr_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a scoreboard queue of expected load results.
// Expected addresses and latencies are derived from the load stimulus.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instruction;
  logic [31:0] base_addr;
  logic [4:0]  dest_reg;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        err;
    logic        rd_seen;
    int          lat;
  } exp_t;

  exp_t sb[$];

  load_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .instruction  (instruction),
    .base_addr    (base_addr),
    .dest_reg     (dest_reg),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dly: REQ cycles without valid before data returns; -1 = never.
  task automatic run_load(input logic [31:0] b,
                          input logic [15:0] im,
                          input logic [4:0]  d,
                          input int          dly,
                          input logic [31:0] dat,
                          input bit          rep,
                          input string       tag);
    exp_t e;
    exp_t x;
    bit   ae;
    bit   got;
    int   cyc;
    int   reqn;
    int   wecnt;
    logic rdseen;
    logic [31:0] aobs;
    e.addr = b + {{16{im[15]}}, im};
`ifdef LOAD_ALIGN_CHECK_EN
    ae = (e.addr[1:0] != 2'b00);
`else
    ae = 1'b0;
`endif
    e.err     = ae || (dly < 0);
    e.we      = !e.err && (d != 5'd0);
    e.waddr   = d;
    e.wdata   = dat;
    e.rd_seen = !ae;
    e.lat     = ae ? 2 : ((dly < 0) ? 17 : 3 + dly);
    sb.push_back(e);

    start       = 1'b1;
    base_addr   = b;
    instruction = im;
    dest_reg    = d;
    tick();
    // Scramble operands: the DUT must hold what it captured.
    base_addr   = 32'hFFFF_FFFF;
    instruction = 16'h1234;
    dest_reg    = 5'h1f;
    cyc    = 1;
    reqn   = 0;
    got    = 0;
    wecnt  = 0;
    rdseen = 1'b0;
    aobs   = '0;
    while (!got && cyc < 40) begin
      start = 1'b0;
      if (mem_rd_en) begin
        rdseen = 1'b1;
        aobs   = mem_addr;
        if (dly >= 0 && reqn == dly) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = dat;
        end else begin
          mem_rd_valid = 1'b0;
          mem_rd_data  = $urandom;
        end
        if (rep && reqn == 1) start = 1'b1;
        reqn++;
      end else begin
        // Stray valid outside REQ must be ignored.
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hBAD0_BAD0;
      end
      if (rf_we) wecnt++;
      if (!done) chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (done) begin
        got = 1;
        x = sb.pop_front();
        chk({tag, "_lat"}, 64'(cyc), 64'(x.lat));
        chk({tag, "_err"}, 64'(error), 64'(x.err));
        chk({tag, "_we"}, 64'(wecnt), 64'(x.we));
        chk({tag, "_rdseen"}, 64'(rdseen), 64'(x.rd_seen));
        if (x.rd_seen) chk({tag, "_addr"}, 64'(aobs), 64'(x.addr));
        if (x.we) begin
          chk({tag, "_waddr"}, 64'(rf_waddr), 64'(x.waddr));
          chk({tag, "_wdata"}, 64'(rf_wdata), 64'(x.wdata));
        end
      end else begin
        tick();
        cyc++;
      end
    end
    if (!got) chk({tag, "_nodone"}, 64'd0, 64'd1);
    start        = 1'b0;
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_idle_done"}, 64'(done), 64'd0);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    instruction  = '0;
    base_addr    = '0;
    dest_reg     = '0;
    mem_rd_data  = '0;
    mem_rd_valid = 1'b0;
    tick();
    tick();
    chk("rst_rden",  64'(mem_rd_en), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_err",   64'(error),     64'd0);
    chk("rst_we",    64'(rf_we),     64'd0);
    chk("rst_addr",  64'(mem_addr),  64'd0);
    chk("rst_waddr", 64'(rf_waddr),  64'd0);
    chk("rst_wdata", 64'(rf_wdata),  64'd0);
    reset = 1'b0;
    tick();

    run_load(32'h0000_0100, 16'h0008, 5'd5, 0,
             32'hDEAD_BEEF, 1'b0, "basic");
    run_load(32'h0000_0100, 16'hFFFC, 5'd7, 3,
             32'hCAFE_F00D, 1'b0, "negoff");
    run_load(32'hFFFF_FFFC, 16'h0008, 5'd9, 1,
             32'h0BAD_CAFE, 1'b0, "wrap");
    run_load(32'h0000_0200, 16'h0010, 5'd3, -1,
             32'h0, 1'b0, "timeout");
    run_load(32'h0000_0300, 16'h0004, 5'd0, 2,
             32'h1234_5678, 1'b1, "r0_repulse");
    run_load(32'h0000_0400, 16'h0000, 5'd12, 2,
             32'h5555_AAAA, 1'b1, "repulse");
    run_load(32'h0000_0000, 16'h7FFC, 5'd31, 14,
             32'hA5A5_5A5A, 1'b0, "lastwait");
    run_load(32'h0000_0101, 16'h0000, 5'd4, 0,
             32'h7777_1111, 1'b0, "misalign");

    // Reset in the middle of a pending read.
    start       = 1'b1;
    base_addr   = 32'h0000_0800;
    instruction = 16'h0000;
    dest_reg    = 5'd6;
    tick();
    start = 1'b0;
    tick();
    chk("mid_rden_pre", 64'(mem_rd_en), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rden",  64'(mem_rd_en), 64'd0);
    chk("mid_busy",  64'(busy),      64'd0);
    chk("mid_done",  64'(done),      64'd0);
    chk("mid_addr",  64'(mem_addr),  64'd0);
    chk("mid_waddr", 64'(rf_waddr),  64'd0);
    for (int i = 0; i < 4; i++) begin
      mem_rd_valid = 1'b1;
      tick();
      chk("mid_quiet_done", 64'(done),  64'd0);
      chk("mid_quiet_we",   64'(rf_we), 64'd0);
    end
    mem_rd_valid = 1'b0;

    run_load(32'h0000_1000, 16'h0020, 5'd2, 1,
             32'h0F0F_F0F0, 1'b0, "after_rst");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
